// File: rtl/handshake_slave_rx.sv
// handshake_slave_rx
// ------------------
// Responder side of the 4-phase req/ack byte handshake. Each req/ack cycle
// delivers one byte into a small first-word-fall-through FIFO. The FIFO is
// drained by a downstream consumer over a valid/ready port. While the FIFO
// is full, ack is withheld, which throttles the master. After NUM_BYTES
// transfers the block sets a sticky done flag and refuses further requests.
// Protocol violations set a sticky proto_err flag.
//
// Parameters
//   NUM_BYTES  transfers expected before done is set
//   DEPTH      FIFO entries (power of 2, >= 2)
//   ACK_DELAY  extra cycles between seeing req high and raising ack (0..15)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req, data   request and byte from the master (data valid while req=1)
//   ack         registered acknowledge to the master
//   out_valid   FIFO non-empty
//   out_data    FIFO head byte, meaningful while out_valid=1
//   out_ready   consumer pops the head when out_valid && out_ready
//   rx_count    bytes accepted since reset, saturating at 255
//   fifo_level  current FIFO occupancy
//   done        sticky, set once NUM_BYTES transfers have completed
//   proto_err   sticky protocol-violation flag

module handshake_slave_rx #(
  parameter int NUM_BYTES = 4,
  parameter int DEPTH     = 4,
  parameter int ACK_DELAY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [7:0]               data,
  output logic                     ack,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [7:0]               rx_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     done,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_WAIT_REQ = 2'd0,
    S_DELAY    = 2'd1,
    S_ACK      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [3:0]         delay_cnt, delay_cnt_next;
  logic               push, pop, full, err_set;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_next;
  logic [7:0]         mem [DEPTH];

  // A pop on the same edge frees a slot, so a full FIFO can still accept a
  // byte when the consumer is taking the head at that moment.
  assign pop  = out_valid && out_ready;
  assign full = (fifo_level == LVL_W'(DEPTH)) && !pop;

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_next     = state;
    delay_cnt_next = delay_cnt;
    push           = 1'b0;
    err_set        = 1'b0;

    case (state)
      S_WAIT_REQ: begin
        if (req && !full) begin
          if (ACK_DELAY == 0) begin
            push       = 1'b1;
            state_next = S_ACK;
          end else begin
            delay_cnt_next = 4'(ACK_DELAY - 1);
            state_next     = S_DELAY;
          end
        end
      end

      S_DELAY: begin
        if (!req) begin
          // Master withdrew req before we acknowledged it.
          err_set    = 1'b1;
          state_next = S_WAIT_REQ;
        end else if (delay_cnt == 4'd0) begin
          if (!full) begin
            push       = 1'b1;
            state_next = S_ACK;
          end else begin
            state_next = S_WAIT_REQ;
          end
        end else begin
          delay_cnt_next = delay_cnt - 4'd1;
        end
      end

      S_ACK: begin
        // rx_count already includes the byte pushed when ack rose.
        if (!req) begin
          state_next = (int'(rx_count) == NUM_BYTES) ? S_DONE : S_WAIT_REQ;
        end
      end

      S_DONE: begin
        if (req) err_set = 1'b1;
      end

      default: state_next = S_WAIT_REQ;
    endcase
  end

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LVL_W'(1);
      2'b01:   level_next = fifo_level - LVL_W'(1);
      default: level_next = fifo_level;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT_REQ;
      delay_cnt  <= 4'd0;
      ack        <= 1'b0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
      rx_count   <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state      <= state_next;
      delay_cnt  <= delay_cnt_next;
      ack        <= (state_next == S_ACK);
      done       <= done | (state_next == S_DONE);
      proto_err  <= proto_err | err_set;
      if (push && rx_count != 8'hFF) rx_count <= rx_count + 8'd1;
      // Pointers are PTR_W bits wide, so they wrap modulo DEPTH by themselves.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      out_valid  <= (level_next != '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is carried
  // by fifo_level and the pointers, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // Head of the FIFO read straight from storage: a byte written into an
  // empty FIFO is visible on the same edge that raises ack and out_valid.
  assign out_data = mem[rd_ptr];

endmodule
